fft_frame_feeder: RTL and testbench
===================================

FFT_FRAME_FEEDER -- requirements
Module: fft_frame_feeder

Interface
REQ-001 Parameter FFT_LEN, default 256: beats per FFT frame; a power of two in the range 8 to 1024.
REQ-002 Parameter DATAIN_WIDTH, default 16: signed sample width.
REQ-003 Parameter FIFO_DEPTH, default 16: sample buffer depth; a power of two.
REQ-004 i_aclk  in  1  sole clock; all logic on rising edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_smp_valid  in  1  audio sample strobe; source cannot stall.
REQ-007 i_smp_data  in  DATAIN_WIDTH  signed real audio sample.
REQ-008 i_fft_dir  in  1  1 = forward FFT, 0 = inverse.
REQ-009 o_axi4s_cfg_tvalid  out  1  config strobe to the FFT core.
REQ-010 o_axi4s_cfg_tdata  out  1  config word; equals the latched direction.
REQ-011 o_axi4s_data_tvalid  out  1  frame data valid.
REQ-012 o_axi4s_data_tdata  out  DATAIN_WIDTH*2  {imag, real}; real occupies the low half.
REQ-013 o_axi4s_data_tlast  out  1  last beat of a frame.
REQ-014 i_axi4s_data_tready  in  1  FFT core accept.
REQ-015 o_frame_cnt  out  8  count of completed frames; wraps modulo 256.
REQ-016 o_ovf  out  1  sticky flag: a sample was dropped.

Function
REQ-017 FIFO write when i_smp_valid=1 and (FIFO not full, or a pop occurs in the same cycle); a write to a full FIFO without a pop drops the sample and sets o_ovf.
REQ-018 A written sample drives tvalid no earlier than the next cycle: 1-cycle minimum latency from i_smp_valid to o_axi4s_data_tvalid.
REQ-019 A pop occurs only on handshake: o_axi4s_data_tvalid & i_axi4s_data_tready.
REQ-020 o_axi4s_data_tdata = {DATAIN_WIDTH'b0, FIFO head}; the imaginary half is always zero.
REQ-021 Once asserted, tvalid, tdata and tlast hold stable until the handshake completes.
REQ-022 Beat counter (log2 FFT_LEN bits) increments on each handshake and returns to 0 after the beat where tlast is accepted.
REQ-023 o_axi4s_data_tlast = 1 exactly when tvalid=1 and beat counter = FFT_LEN-1.
REQ-024 o_frame_cnt increments on the cycle tlast is accepted.
REQ-025 FSM states: CFG, STREAM.
- CFG: cfg_tvalid=1 for exactly one cycle, data tvalid=0, next state STREAM.
- STREAM: data tvalid = FIFO not empty.
REQ-026 On entry to CFG, i_fft_dir is latched into a direction register that drives o_axi4s_cfg_tdata.
REQ-027 In STREAM, when i_fft_dir differs from the latched direction and beat counter = 0 with no handshake pending, the FSM goes to CFG; mid-frame direction changes wait for the frame boundary.
REQ-028 Simultaneous FIFO write and pop leaves the FIFO occupancy unchanged.
REQ-029 The FIFO pointers wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit.
REQ-030 Samples continue to be buffered during CFG; none are popped.

Reset
REQ-031 While i_rst=1, all outputs are 0, the FIFO is empty, the beat counter is 0, and the FSM is in CFG.
REQ-032 In the first cycle after reset deassertion, o_axi4s_cfg_tvalid=1 with o_axi4s_cfg_tdata = i_fft_dir.
REQ-033 Reset asserted mid-frame discards the partial frame and buffered samples; the next frame starts at beat 0.
REQ-034 o_ovf clears only on reset.

Verification
REQ-035 Release reset with i_fft_dir=1 -> exactly one cfg_tvalid pulse with tdata=1 in cycle 1, then no further pulse.
REQ-036 Continuous i_smp_valid, i_smp_data=1, tready=1 -> tdata=32'h0000_0001 every beat; tlast on beats 255, 511, ...; o_frame_cnt=2 after 512 beats; o_ovf=0.
REQ-037 tready=0 for 20 cycles while samples arrive every cycle -> 16 buffered, 4 dropped, o_ovf=1; tdata is stable throughout the stall; after release the 16 samples emerge in order.
REQ-038 Toggle i_fft_dir to 0 at beat 100 -> no cfg pulse until after tlast; a single pulse with tdata=0 occurs before beat 0 of the next frame.
REQ-039 Assert i_rst at beat 130 -> outputs are 0 immediately (asynchronous); after release a cfg pulse occurs, then the next tlast falls on beat 255 of the new count.

Source files
------------

// File: rtl/fft_frame_feeder_if.sv
// Bundle of the sample-source, FFT-config and FFT-data streams seen by fft_frame_feeder.
// The master modport is the feeder's view; the slave modport is the surrounding system's view.
interface fft_frame_feeder_if #(
  parameter int DATAIN_WIDTH = 16
) ();

  logic                          i_smp_valid;
  logic signed [DATAIN_WIDTH-1:0] i_smp_data;
  logic                          i_fft_dir;

  logic                          o_axi4s_cfg_tvalid;
  logic                          o_axi4s_cfg_tdata;

  logic                          o_axi4s_data_tvalid;
  logic [2*DATAIN_WIDTH-1:0]     o_axi4s_data_tdata;
  logic                          o_axi4s_data_tlast;
  logic                          i_axi4s_data_tready;

  logic [7:0]                    o_frame_cnt;
  logic                          o_ovf;

  modport master (
    input  i_smp_valid,
    input  i_smp_data,
    input  i_fft_dir,
    output o_axi4s_cfg_tvalid,
    output o_axi4s_cfg_tdata,
    output o_axi4s_data_tvalid,
    output o_axi4s_data_tdata,
    output o_axi4s_data_tlast,
    input  i_axi4s_data_tready,
    output o_frame_cnt,
    output o_ovf
  );

  modport slave (
    output i_smp_valid,
    output i_smp_data,
    output i_fft_dir,
    input  o_axi4s_cfg_tvalid,
    input  o_axi4s_cfg_tdata,
    input  o_axi4s_data_tvalid,
    input  o_axi4s_data_tdata,
    input  o_axi4s_data_tlast,
    output i_axi4s_data_tready,
    input  o_frame_cnt,
    input  o_ovf
  );

endinterface

// File: rtl/fft_frame_feeder.sv
// Buffers a non-stallable real audio stream and feeds it to an FFT core as fixed-length
// complex frames, issuing a config word whenever the transform direction changes.
module fft_frame_feeder #(
  parameter int FFT_LEN      = 256,
  parameter int DATAIN_WIDTH = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                i_aclk,
  input  logic                i_rst,
  fft_frame_feeder_if.master  bus
);

  localparam int BEAT_W = $clog2(FFT_LEN);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  typedef enum logic {
    ST_CFG,
    ST_STREAM
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]          rd_ptr_q, rd_ptr_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [7:0]              frame_cnt_q, frame_cnt_d;
  logic                    ovf_q, ovf_d;
  logic                    dir_q, dir_d;
  logic [DATAIN_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic data_tvalid;
  logic data_tlast;
  logic pop;
  logic push;
  logic dir_change;
  logic [DATAIN_WIDTH-1:0] fifo_head;

  // The extra pointer MSB separates a full FIFO from an empty one.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {PTR_W{1'b0}}});
  assign fifo_head  = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    beat_d      = beat_q;
    frame_cnt_d = frame_cnt_q;
    ovf_d       = ovf_q;
    dir_d       = dir_q;

    data_tvalid = (state_q == ST_STREAM) && !fifo_empty;
    data_tlast  = data_tvalid && (beat_q == BEAT_W'(FFT_LEN - 1));
    pop         = data_tvalid && bus.i_axi4s_data_tready;
    push        = bus.i_smp_valid && (!fifo_full || pop);
    dir_change  = (bus.i_fft_dir != dir_q);

    if (push) begin
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
    if (bus.i_smp_valid && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end

    if (pop) begin
      if (data_tlast) begin
        beat_d      = '0;
        frame_cnt_d = frame_cnt_q + 8'd1;
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end

    // A direction change is honoured only on a frame boundary with nothing left in flight.
    case (state_q)
      ST_CFG: begin
        dir_d   = bus.i_fft_dir;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (dir_change &&
            (((beat_q == '0) && !data_tvalid) || (pop && data_tlast))) begin
          state_d = ST_CFG;
        end
      end
      default: state_d = ST_CFG;
    endcase
  end

  always_ff @(posedge i_aclk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_CFG;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      beat_q      <= '0;
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
      dir_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      beat_q      <= beat_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
      dir_q       <= dir_d;
    end
  end

  // Sample storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge i_aclk) begin
    if (push && !i_rst) begin
      fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= bus.i_smp_data;
    end
  end

  assign bus.o_axi4s_cfg_tvalid  = (state_q == ST_CFG) && !i_rst;
  assign bus.o_axi4s_cfg_tdata   = (state_q == ST_CFG) ? (bus.i_fft_dir && !i_rst) : dir_q;
  assign bus.o_axi4s_data_tvalid = data_tvalid;
  assign bus.o_axi4s_data_tdata  = data_tvalid ? {{DATAIN_WIDTH{1'b0}}, fifo_head} : '0;
  assign bus.o_axi4s_data_tlast  = data_tlast;
  assign bus.o_frame_cnt         = frame_cnt_q;
  assign bus.o_ovf               = ovf_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed-plus-random bench for fft_frame_feeder, checked every cycle against a
// queue-based reference model of the frame feeder's rules.
module tb_fft_frame_feeder;

  localparam int FFT_LEN = 256;
  localparam int DW      = 16;
  localparam int DEPTH   = 16;

  logic clk = 1'b0;
  logic rst;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  fft_frame_feeder_if #(.DATAIN_WIDTH(DW)) bus ();

  fft_frame_feeder #(
    .FFT_LEN      (FFT_LEN),
    .DATAIN_WIDTH (DW),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_aclk (clk),
    .i_rst  (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model: buffered samples, position in frame, frames done, sticky drop flag,
  // whether the next cycle is a config cycle, and the direction last sent to the core.
  logic [DW-1:0] mdl_q [$];
  int            mdl_beat;
  int            mdl_frames;
  bit            mdl_ovf;
  bit            mdl_in_cfg;
  bit            mdl_dir;

  task automatic model_reset();
    mdl_q.delete();
    mdl_beat   = 0;
    mdl_frames = 0;
    mdl_ovf    = 1'b0;
    mdl_in_cfg = 1'b1;
    mdl_dir    = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_cnt++;
    assert (obs === exp)
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    bit          exp_cfg_v, exp_cfg_d, exp_tv, exp_tl;
    logic [63:0] exp_td;
    int          exp_fc;
    bit          exp_ovf;
    if (rst) begin
      exp_cfg_v = 0; exp_cfg_d = 0; exp_tv = 0; exp_tl = 0;
      exp_td = '0; exp_fc = 0; exp_ovf = 0;
    end else begin
      exp_cfg_v = mdl_in_cfg;
      exp_cfg_d = mdl_in_cfg ? bus.i_fft_dir : mdl_dir;
      exp_tv    = !mdl_in_cfg && (mdl_q.size() > 0);
      exp_td    = exp_tv ? 64'(mdl_q[0]) : 64'd0;
      exp_tl    = exp_tv && (mdl_beat == FFT_LEN - 1);
      exp_fc    = mdl_frames % 256;
      exp_ovf   = mdl_ovf;
    end
    check("cfg_tvalid",  bus.o_axi4s_cfg_tvalid,  exp_cfg_v);
    check("cfg_tdata",   bus.o_axi4s_cfg_tdata,   exp_cfg_d);
    check("data_tvalid", bus.o_axi4s_data_tvalid, exp_tv);
    check("data_tdata",  bus.o_axi4s_data_tdata,  exp_td);
    check("data_tlast",  bus.o_axi4s_data_tlast,  exp_tl);
    check("frame_cnt",   bus.o_frame_cnt,         64'(exp_fc));
    check("ovf",         bus.o_ovf,               exp_ovf);
  endtask

  task automatic model_advance();
    bit tv, last, pop;
    if (rst) begin
      model_reset();
      return;
    end
    tv   = !mdl_in_cfg && (mdl_q.size() > 0);
    last = tv && (mdl_beat == FFT_LEN - 1);
    pop  = tv && bus.i_axi4s_data_tready;
    if (mdl_in_cfg) begin
      mdl_in_cfg = 1'b0;
      mdl_dir    = bus.i_fft_dir;
    end else if ((bus.i_fft_dir != mdl_dir) &&
                 ((mdl_beat == 0 && !tv) || (pop && last))) begin
      mdl_in_cfg = 1'b1;
    end
    if (pop) begin
      void'(mdl_q.pop_front());
      if (last) begin
        mdl_beat = 0;
        mdl_frames++;
      end else begin
        mdl_beat++;
      end
    end
    if (bus.i_smp_valid) begin
      if (mdl_q.size() < DEPTH) mdl_q.push_back(bus.i_smp_data);
      else                      mdl_ovf = 1'b1;
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic v, input logic [DW-1:0] d,
                                input logic dir, input logic rdy);
    @(negedge clk);
    rst                     = r;
    bus.i_smp_valid         = v;
    bus.i_smp_data          = d;
    bus.i_fft_dir           = dir;
    bus.i_axi4s_data_tready = rdy;
    #1;
    check_output();
    model_advance();
  endtask

  initial begin
    logic cur_dir;
    rst                     = 1'b1;
    bus.i_smp_valid         = 1'b0;
    bus.i_smp_data          = '0;
    bus.i_fft_dir           = 1'b1;
    bus.i_axi4s_data_tready = 1'b1;
    model_reset();

    // Held in reset: everything quiet, even with a sample offered.
    repeat (3) apply_stimulus(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1);

    // Release with forward direction, then a constant unit sample stream for > 512 beats.
    repeat (600) apply_stimulus(1'b0, 1'b1, 16'h0001, 1'b1, 1'b1);
    check("frames_after_512", bus.o_frame_cnt, 64'd2);
    check("ovf_after_stream", bus.o_ovf, 64'd0);

    // Drain, then stall the core for 20 cycles while samples keep arriving.
    repeat (3) apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++)
      apply_stimulus(1'b0, 1'b1, DW'($urandom), 1'b1, 1'b0);
    check("ovf_after_stall", bus.o_ovf, 64'd1);
    repeat (40) apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Stream until beat 100, then flip to inverse mid-frame.
    for (int i = 0; i < 1000 && mdl_beat != 100; i++)
      apply_stimulus(1'b0, 1'b1, DW'($urandom), 1'b1, 1'b1);
    check("reach_beat_100", 64'(mdl_beat), 64'd100);
    repeat (400) apply_stimulus(1'b0, 1'b1, DW'($urandom), 1'b0, 1'b1);
    check("dir_latched_inverse", bus.o_axi4s_cfg_tdata, 64'd0);

    // Asynchronous reset at beat 130, then a fresh frame count.
    for (int i = 0; i < 1000 && mdl_beat != 130; i++)
      apply_stimulus(1'b0, 1'b1, DW'($urandom), 1'b0, 1'b1);
    check("reach_beat_130", 64'(mdl_beat), 64'd130);
    apply_stimulus(1'b1, 1'b1, DW'($urandom), 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b1, DW'($urandom), 1'b0, 1'b1);
    repeat (300) apply_stimulus(1'b0, 1'b1, DW'($urandom), 1'b0, 1'b1);
    check("frames_after_reset", bus.o_frame_cnt, 64'd1);

    // Random traffic: bursty source, bursty sink, occasional direction flips.
    cur_dir = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) cur_dir = ~cur_dir;
      apply_stimulus(1'b0, ($urandom_range(0, 3) != 0), DW'($urandom), cur_dir,
                     ($urandom_range(0, 9) < 7));
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
